// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants and state encoding for the nibble-serial adder
package alu_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_add_ctrl_if.sv
// rtl/nibble_serial_add_ctrl_if.sv - start/busy/done request bus between the ALU and the serial adder
interface nibble_serial_add_ctrl_if #(
  parameter int WIDTH = 16
);

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             c_out;
  logic             overflow;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, c_out, overflow
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, c_out, overflow
  );

endinterface

// File: rtl/ripple_carry_adder_4b.sv
// rtl/ripple_carry_adder_4b.sv - 4-bit ripple-carry adder with carry-out and signed overflow
module ripple_carry_adder_4b (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out,
  output logic       overflow
);

  logic c1, c2, c3, c4;

  assign sum[0] = a[0] ^ b[0] ^ c_in;
  assign c1     = (a[0] & b[0]) | (c_in & (a[0] ^ b[0]));
  assign sum[1] = a[1] ^ b[1] ^ c1;
  assign c2     = (a[1] & b[1]) | (c1 & (a[1] ^ b[1]));
  assign sum[2] = a[2] ^ b[2] ^ c2;
  assign c3     = (a[2] & b[2]) | (c2 & (a[2] ^ b[2]));
  assign sum[3] = a[3] ^ b[3] ^ c3;
  assign c4     = (a[3] & b[3]) | (c3 & (a[3] ^ b[3]));

  assign c_out    = c4;
  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign overflow = c3 ^ c4;

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// rtl/nibble_serial_add_ctrl.sv - WIDTH-bit add/subtract computed one nibble per clock on a shared 4-bit adder
module nibble_serial_add_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  nibble_serial_add_ctrl_if.slave bus
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic                carry;
  logic [WIDTH-1:0]    a_reg;
  logic [WIDTH-1:0]    b_reg;
  logic [WIDTH-1:0]    result_q;
  logic                busy_q;
  logic                done_q;
  logic                c_out_q;
  logic                overflow_q;

  logic [NIBBLE_W-1:0] nib_a;
  logic [NIBBLE_W-1:0] nib_b;
  logic [NIBBLE_W-1:0] nib_sum;
  logic                nib_c;
  logic                nib_ov;

  assign nib_a = a_reg[idx*NIBBLE_W +: NIBBLE_W];
  assign nib_b = b_reg[idx*NIBBLE_W +: NIBBLE_W];

  ripple_carry_adder_4b u_adder (
    .a        (nib_a),
    .b        (nib_b),
    .c_in     (carry),
    .sum      (nib_sum),
    .c_out    (nib_c),
    .overflow (nib_ov)
  );

  // Subtraction is a + ~b + 1: B is inverted at latch time and the +1 enters as the initial carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      carry      <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      result_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      c_out_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (bus.start) begin
            a_reg    <= bus.a;
            b_reg    <= bus.sub ? ~bus.b : bus.b;
            carry    <= bus.sub;
            idx      <= '0;
            result_q <= '0;
            busy_q   <= 1'b1;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          result_q[idx*NIBBLE_W +: NIBBLE_W] <= nib_sum;
          carry <= nib_c;
          if (idx == IDX_LAST) begin
            c_out_q    <= nib_c;
            overflow_q <= nib_ov;
            done_q     <= 1'b1;
            state      <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.c_out    = c_out_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb/tb_nibble_serial_add_ctrl.sv - directed self-checking bench for the nibble-serial adder (WIDTH 16 and 4)
module tb_nibble_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  nibble_serial_add_ctrl_if #(.WIDTH(16)) bus16 ();
  nibble_serial_add_ctrl_if #(.WIDTH(4))  bus4 ();

  nibble_serial_add_ctrl #(.WIDTH(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16.slave)
  );

  nibble_serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  task automatic test_reset();
    checks++; if (bus16.busy !== 1'b0) begin errors++; $display("FAIL reset_busy16: got %b want 0", bus16.busy); end
    checks++; if (bus16.done !== 1'b0) begin errors++; $display("FAIL reset_done16: got %b want 0", bus16.done); end
    checks++; if (bus16.result !== 16'h0000) begin errors++; $display("FAIL reset_result16: got %h want 0000", bus16.result); end
    checks++; if (bus16.c_out !== 1'b0) begin errors++; $display("FAIL reset_cout16: got %b want 0", bus16.c_out); end
    checks++; if (bus16.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf16: got %b want 0", bus16.overflow); end
    checks++; if (bus4.busy !== 1'b0 || bus4.done !== 1'b0) begin errors++; $display("FAIL reset_bd4: got busy=%b done=%b want 0 0", bus4.busy, bus4.done); end
    checks++; if (bus4.result !== 4'h0) begin errors++; $display("FAIL reset_result4: got %h want 0", bus4.result); end
  endtask

  // Caller is at a negedge with the DUT idle; operands are driven now and accepted at the next posedge.
  task automatic run16(input logic [15:0] op_a, input logic [15:0] op_b, input logic op_sub,
                       input logic [15:0] exp_r, input logic exp_c, input logic exp_o,
                       input bit inject, input string name);
    int n_busy;
    int n_done;
    int done_at;
    n_busy = 0; n_done = 0; done_at = 0;
    bus16.a = op_a; bus16.b = op_b; bus16.sub = op_sub; bus16.start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      if (bus16.busy === 1'b1) n_busy++;
      if (bus16.done === 1'b1) begin
        n_done++;
        if (done_at == 0) done_at = cyc;
      end
      if (cyc == 5) begin
        checks++; if (bus16.result !== exp_r) begin errors++; $display("FAIL %s_result: got %h want %h", name, bus16.result, exp_r); end
        checks++; if (bus16.c_out !== exp_c) begin errors++; $display("FAIL %s_cout: got %b want %b", name, bus16.c_out, exp_c); end
        checks++; if (bus16.overflow !== exp_o) begin errors++; $display("FAIL %s_ovf: got %b want %b", name, bus16.overflow, exp_o); end
      end
      if (cyc == 6) begin
        checks++; if (bus16.result !== exp_r) begin errors++; $display("FAIL %s_held: got %h want %h", name, bus16.result, exp_r); end
      end
      bus16.start = inject && (cyc == 1 || cyc == 5);
      bus16.a     = 16'hAAAA;
      bus16.b     = 16'h5555;
      bus16.sub   = ~op_sub;
    end
    checks++; if (n_busy != 5) begin errors++; $display("FAIL %s_busy_cycles: got %0d want 5", name, n_busy); end
    checks++; if (n_done != 1) begin errors++; $display("FAIL %s_done_pulses: got %0d want 1", name, n_done); end
    checks++; if (done_at != 5) begin errors++; $display("FAIL %s_done_cycle: got %0d want 5", name, done_at); end
  endtask

  task automatic test_add();
    run16(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0, "add_basic");
    run16(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, "add_ovf");
    run16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, "add_wrap");
  endtask

  task automatic test_sub();
    run16(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, "sub_borrow");
    run16(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, "sub_ovf");
  endtask

  // Spurious starts land in RUN and DONE; the next op is launched in the very next IDLE cycle.
  task automatic test_back_to_back();
    run16(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b1, "ignore_busy");
    run16(16'h0100, 16'h0023, 1'b0, 16'h0123, 1'b0, 1'b0, 1'b0, "b2b_accept");
  endtask

  task automatic test_mid_reset();
    bit saw_activity;
    saw_activity = 1'b0;
    bus16.a = 16'h1234; bus16.b = 16'h0FFF; bus16.sub = 1'b0; bus16.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus16.start = 1'b0;
    @(negedge clk);
    checks++; if (bus16.result !== 16'h0003 || bus16.busy !== 1'b1) begin errors++; $display("FAIL rst_partial: got result=%h busy=%b want 0003 1", bus16.result, bus16.busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus16.busy !== 1'b0 || bus16.done !== 1'b0) begin errors++; $display("FAIL rst_async_bd: got busy=%b done=%b want 0 0", bus16.busy, bus16.done); end
    checks++; if (bus16.result !== 16'h0000) begin errors++; $display("FAIL rst_async_result: got %h want 0000", bus16.result); end
    checks++; if (bus16.c_out !== 1'b0 || bus16.overflow !== 1'b0) begin errors++; $display("FAIL rst_async_flags: got c=%b o=%b want 0 0", bus16.c_out, bus16.overflow); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus16.done !== 1'b0 || bus16.busy !== 1'b0) saw_activity = 1'b1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus16.done !== 1'b0 || bus16.busy !== 1'b0) saw_activity = 1'b1;
    end
    checks++; if (saw_activity) begin errors++; $display("FAIL rst_no_done: got activity=1 want 0"); end
    run16(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, "post_reset");
  endtask

  task automatic test_width4();
    int n_busy;
    int done_at;
    n_busy = 0; done_at = 0;
    bus4.a = 4'h7; bus4.b = 4'h1; bus4.sub = 1'b0; bus4.start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(negedge clk);
      bus4.start = 1'b0;
      if (bus4.busy === 1'b1) n_busy++;
      if (bus4.done === 1'b1 && done_at == 0) done_at = cyc;
      if (cyc == 2) begin
        checks++; if (bus4.result !== 4'h8) begin errors++; $display("FAIL w4_result: got %h want 8", bus4.result); end
        checks++; if (bus4.c_out !== 1'b0 || bus4.overflow !== 1'b1) begin errors++; $display("FAIL w4_flags: got c=%b o=%b want 0 1", bus4.c_out, bus4.overflow); end
      end
    end
    checks++; if (done_at != 2) begin errors++; $display("FAIL w4_done_cycle: got %0d want 2", done_at); end
    checks++; if (n_busy != 2) begin errors++; $display("FAIL w4_busy_cycles: got %0d want 2", n_busy); end
  endtask

  initial begin
    rst_n = 1'b0;
    bus16.start = 1'b0; bus16.sub = 1'b0; bus16.a = '0; bus16.b = '0;
    bus4.start  = 1'b0; bus4.sub  = 1'b0; bus4.a  = '0; bus4.b  = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_add();
    test_sub();
    test_back_to_back();
    test_mid_reset();
    test_width4();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
